// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, IDLE/FETCH/HOLD FSM and decode-facing output register.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_en_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [XLEN-1:0]   imem_rd_i,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              misalign_o,
  output logic [1:0]        state_o
);

  // Handshake: an instruction transfers to decode on any rising edge where
  // valid_o && ready_i; instr_o/pc_o stay stable while valid_o && !ready_i.

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_out_q;
  logic            valid_q;
  logic            misalign_q;
  logic            capture;
  logic            bad_target;
  logic            stopped;

`ifdef FETCH_ALIGN_CHECK_EN
  // Set by a misaligned redirect; only an aligned redirect restarts fetch.
  logic stopped_q;
  assign stopped    = stopped_q;
  assign bad_target = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  assign stopped    = 1'b0;
  assign bad_target = 1'b0;
`endif

  assign capture = fetch_en_i && (!valid_q || ready_i) && !redirect_i && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = (fetch_en_i && !bad_target) ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en_i && !stopped) state_d = FETCH;
        end
        FETCH, HOLD: begin
          if (valid_q && !ready_i) state_d = HOLD;
          else if (!fetch_en_i)    state_d = IDLE;
          else                     state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= 1'b0;
      if (redirect_i) begin
        // Any transfer this cycle completes; the word at the RAM is dropped.
        valid_q <= 1'b0;
        pc_q    <= redirect_pc_i & ~32'h3;
        if (bad_target) begin
          misalign_q <= 1'b1;
          pc_out_q   <= redirect_pc_i;
        end
      end else if (capture) begin
        instr_q  <= imem_rd_i;
        pc_out_q <= pc_q;
        valid_q  <= 1'b1;
        pc_q     <= pc_q + 32'd4;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)           stopped_q <= 1'b0;
    else if (redirect_i) stopped_q <= bad_target;
  end
`endif

  assign imem_addr_o = pc_q[ADDR_W+1:2];
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign valid_o     = valid_q;
  assign misalign_o  = misalign_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural RAM and a transfer scoreboard.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              fetch_en_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rd_i;
  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic              valid_o;
  logic              ready_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              misalign_o;
  logic [1:0]        state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  // RAM: word k holds 0x1000_0000 + k
  always_comb imem_rd_i = 32'h1000_0000 + {{(32-ADDR_W){1'b0}}, imem_addr_o};

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .fetch_en_i    (fetch_en_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rd_i     (imem_rd_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .misalign_o    (misalign_o),
    .state_o       (state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Expected transfer for byte PC pc, derived from the RAM contents.
  task automatic push(input logic [31:0] pc);
    logic [31:0] word;
    word = (pc >> 2) & ((32'd1 << ADDR_W) - 32'd1);
    exp_q.push_back({pc, 32'h1000_0000 + word});
  endtask

  // Score any transfer in the current cycle, then advance to the next negedge.
  task automatic tick();
    logic [63:0] e;
    if (valid_o && ready_i) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL xfer_unexpected: observed pc %h expected none", pc_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_pc", pc_o, e[63:32]);
        chk("xfer_instr", instr_o, e[31:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1; fetch_en_i = 1'b0; ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    tick(); tick();

    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, NOP_INSTR);
    chk("rst_state", {30'b0, state_o}, {30'b0, IDLE});
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
    chk("rst_addr", {23'b0, imem_addr_o}, 32'd0);

    // Streaming fetch
    rst_i = 1'b0; fetch_en_i = 1'b1; ready_i = 1'b1;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    chk("c1_state", {30'b0, state_o}, {30'b0, IDLE});
    chk("c1_valid", {31'b0, valid_o}, 32'd0);
    tick();
    chk("c2_valid", {31'b0, valid_o}, 32'd0);
    chk("c2_addr", {23'b0, imem_addr_o}, 32'd0);
    tick();
    tick();
    tick();

    // Stall for three cycles while pc_o=8
    chk("stall_pc", pc_o, 32'h8);
    chk("stall_valid", {31'b0, valid_o}, 32'd1);
    ready_i = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("hold_pc", pc_o, 32'h8);
      chk("hold_instr", instr_o, 32'h1000_0002);
      chk("hold_addr", {23'b0, imem_addr_o}, 32'd3);
      chk("hold_state", {30'b0, state_o}, {30'b0, HOLD});
      chk("hold_valid", {31'b0, valid_o}, 32'd1);
      tick();
    end
    ready_i = 1'b1;
    tick();
    chk("nobubble_pc", pc_o, 32'hC);
    tick();

    // Redirect to 0x40 concurrent with a transfer of 0x10
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    push(32'h40); push(32'h44);
    tick();
    redirect_i = 1'b0;
    chk("redir_bubble", {31'b0, valid_o}, 32'd0);
    tick();
    chk("redir_pc", pc_o, 32'h40);
    tick();

    // Redirect to the last RAM word and wrap to word 0
    redirect_i = 1'b1; redirect_pc_i = 32'h7FC;
    push(32'h7FC); push(32'h800);
    tick();
    redirect_i = 1'b0;
    chk("wrap_bubble", {31'b0, valid_o}, 32'd0);
    chk("wrap_addr", {23'b0, imem_addr_o}, 32'd511);
    tick();
    tick();
    tick();
    ready_i = 1'b0;
    chk("wrap_pc", pc_o, 32'h804);
    chk("wrap_instr", instr_o, 32'h1000_0001);
    tick();

    // Reset while holding
    chk("pre_rst_state", {30'b0, state_o}, {30'b0, HOLD});
    rst_i = 1'b1;
    tick();
    chk("hrst_valid", {31'b0, valid_o}, 32'd0);
    chk("hrst_pc", pc_o, 32'h0);
    chk("hrst_instr", instr_o, NOP_INSTR);
    chk("hrst_state", {30'b0, state_o}, {30'b0, IDLE});

    // Back-to-back redirects: last one wins
    rst_i = 1'b0; fetch_en_i = 1'b1; ready_i = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    chk("b2b_valid1", {31'b0, valid_o}, 32'd0);
    redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    chk("b2b_valid2", {31'b0, valid_o}, 32'd0);
    push(32'h200); push(32'h204);
    tick();
    tick();

    // Misaligned redirect target 0x42
    redirect_i = 1'b1; redirect_pc_i = 32'h42;
    tick();
    redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
    chk("mis_pc", pc_o, 32'h42);
    chk("mis_valid", {31'b0, valid_o}, 32'd0);
    chk("mis_state", {30'b0, state_o}, {30'b0, IDLE});
    tick();
    chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
    chk("mis_stop_valid", {31'b0, valid_o}, 32'd0);
    tick();
    chk("mis_stop_valid2", {31'b0, valid_o}, 32'd0);
    chk("mis_stop_state", {30'b0, state_o}, {30'b0, IDLE});
    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    push(32'h80);
    tick();
    redirect_i = 1'b0;
    chk("realign_bubble", {31'b0, valid_o}, 32'd0);
    tick();
    tick();
`else
    chk("mis_tied", {31'b0, misalign_o}, 32'd0);
    chk("mis_valid", {31'b0, valid_o}, 32'd0);
    push(32'h40); push(32'h44);
    tick();
    tick();
    tick();
`endif

    ready_i = 1'b0;
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage sitting directly upstream of the instruction RAM.
- Holds the program counter and drives the RAM word address.
- Captures the RAM's combinational read data into an output register, which it presents to decode with a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump) and flushes the in-flight instruction when one arrives.

Parameters:
- ADDR_W, 9, width of the RAM word address; the RAM holds 2^ADDR_W 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- fetch_en_i  input  1  allows new fetches; when low, no PC advance.
- imem_addr_o  output  ADDR_W  RAM word address, equal to pc_q[ADDR_W+1:2].
- imem_rd_i  input  32  RAM read data, combinational from imem_addr_o.
- instr_o  output  32  fetched instruction.
- pc_o  output  32  byte PC of instr_o.
- valid_o  output  1  instr_o/pc_o hold a live instruction.
- ready_i  input  1  decode accepts the instruction this cycle.
- redirect_i  input  1  load a new PC.
- redirect_pc_i  input  32  redirect target (byte address).
- misalign_o  output  1  one-cycle pulse for a misaligned redirect target (optional feature).

Behaviour:
- Reset (rst_i high at an edge):
  - pc_q=RESET_PC, state=IDLE.
  - valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=RESET_PC, misalign_o=0.
  - Reset wins over every other input, including mid-stall or mid-redirect.
- State machine IDLE / FETCH / HOLD:
  - IDLE: valid_o=0. Moves to FETCH when fetch_en_i=1.
  - FETCH:
    - Each edge: instr_o<=imem_rd_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4.
    - Moves to HOLD if the new output is not accepted next cycle.
    - fetch_en_i=0: no capture; state goes to IDLE once valid_o has drained (valid_o=0, or valid_o=1 with ready_i=1).
  - HOLD: valid_o=1, ready_i=0. instr_o, pc_o, pc_q and imem_addr_o are all frozen. On ready_i=1, behaves as FETCH in the same cycle (zero-bubble).
- Capture condition: fetch_en_i && (!valid_o || ready_i) && !redirect_i.
- Throughput and latency:
  - Throughput: one instruction per cycle while ready_i=1.
  - Latency: address driven in cycle N, instruction valid on the output in cycle N+1.
- Redirect: highest priority after reset.
  - Same edge: pc_q<=redirect_pc_i (low 2 bits forced 00 unless the optional feature applies), valid_o<=0, state<=FETCH if fetch_en_i else IDLE.
  - Cost: exactly one bubble cycle; the first target instruction is valid two edges after redirect_i is asserted.
  - A simultaneous valid_o&&ready_i transfer completes (decode consumed it); the instruction in flight at the RAM is discarded.
  - A redirect during HOLD drops the held instruction.
- Arithmetic and wrap-around:
  - pc_q+4 wraps modulo 2^32.
  - imem_addr_o truncates, so fetch wraps from word 2^ADDR_W-1 to word 0 (byte 0x7FC to 0x800 reads word 0 for ADDR_W=9).
  - pc_o keeps the full 32-bit value.
- Back-to-back redirects on consecutive cycles: the last one wins; valid_o stays 0 throughout.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 pulses misalign_o=1 for the next cycle.
  - pc_o<=redirect_pc_i, valid_o stays 0, state goes to IDLE.
  - Fetch stays stopped until an aligned redirect arrives; fetch_en_i alone does not restart it.
- Undefined: low bits are silently cleared, misalign_o is tied 0, and no extra state exists.

Decomposition:
- Package fetch_pkg:
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - fetch_state_t enum {IDLE, FETCH, HOLD}.
  - Default RESET_PC constant.
- No sub-module: PC register, FSM and output register stay in one module.
- The bench instantiates instr_fetch with the existing RAM connected through imem_addr_o / imem_rd_i.

Test Plan:
- Reset, fetch_en_i=1, ready_i=1, RAM word k = 32'h1000_0000+k -> from cycle 2 after reset release, one instruction per cycle: pc_o=0,4,8,…, instr_o=0x1000_0000,0x1000_0001,….
- ready_i=0 for 3 cycles while pc_o=0x8 -> instr_o=0x1000_0002 and pc_o=0x8 held, imem_addr_o frozen at 3; ready_i=1 -> next cycle pc_o=0xC with no bubble.
- redirect_i=1, redirect_pc_i=0x40 while valid_o&&ready_i -> current instruction accepted; next cycle valid_o=0; the following cycle pc_o=0x40, instr_o=0x1000_0010.
- redirect to 0x7FC with ADDR_W=9 -> pc_o=0x7FC (word 511), then pc_o=0x800 with instr_o from word 0.
- rst_i asserted during HOLD -> next edge valid_o=0, pc_o=RESET_PC, instr_o=0x13, state IDLE.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> misalign_o=1 for one cycle, pc_o=0x42, valid_o=0, no further fetch until an aligned redirect; without the macro -> fetch resumes at 0x40.
